// File: rtl/board_row_streamer.sv
// Snapshots the flattened Tetris board on start and streams it one row per beat,
// top row first, flagging full rows and counting them per frame.
module board_row_streamer #(
  parameter int ROWS       = 23,
  parameter int COLS       = 10,
  parameter int IDX_W      = 5,
  parameter bit SKIP_EMPTY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] board_flattened,
  input  logic                 start,
  output logic                 busy,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [COLS-1:0]      row_data,
  output logic [IDX_W-1:0]     row_idx,
  output logic                 row_last,
  output logic                 row_full,
  output logic                 done,
  output logic [IDX_W-1:0]     full_count,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_t                 state, state_next;
  logic [ROWS*COLS-1:0]   snapshot;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       run_cnt;
  logic [IDX_W-1:0]       run_next;
  logic                   advance;
  logic                   at_last;

  // Row 0 sits in the most significant COLS bits of the flattened board.
  function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] b,
                                             input logic [IDX_W-1:0] r);
    row_of = b[(ROWS - int'(r))*COLS - 1 -: COLS];
  endfunction

  assign at_last   = (ptr == LAST_IDX);
  assign fsm_state = state;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign row_idx   = ptr;
  assign row_last  = (state == STREAM) && at_last;
  assign row_full  = &row_data;
  assign run_next  = run_cnt + IDX_W'(row_valid && row_ready && row_full);

  // Handshake: a beat transfers on a cycle where row_valid && row_ready; while
  // row_valid is high and row_ready low, every row_* output holds its value.
  always_comb begin
    state_next = state;
    row_valid  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        row_valid = !SKIP_EMPTY || (|row_data);
        advance   = row_valid ? row_ready : 1'b1;
        if (advance && at_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot   <= '0;
      ptr        <= '0;
      row_data   <= '0;
      run_cnt    <= '0;
      full_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= board_flattened;
            ptr      <= '0;
            row_data <= row_of(board_flattened, '0);
            run_cnt  <= '0;
          end
        end
        STREAM: begin
          if (advance) begin
            run_cnt <= run_next;
            if (at_last) begin
              // Publish the count including the final beat, and park the row outputs at zero.
              full_count <= run_next;
              ptr        <= '0;
              row_data   <= '0;
            end else begin
              ptr      <= ptr + 1'b1;
              row_data <= row_of(snapshot, ptr + 1'b1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_row_streamer.sv
// Bench for board_row_streamer: default 23x10 instance and a 4x6 SKIP_EMPTY instance,
// with an expected-row queue checked as beats are presented.
module tb_board_row_streamer;

  localparam int AR = 23;
  localparam int AC = 10;
  localparam int AI = 5;
  localparam int BR = 4;
  localparam int BC = 6;
  localparam int BI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst, a_start, a_ready;
  logic [AR*AC-1:0]  a_board;
  logic              a_busy, a_row_valid, a_row_last, a_row_full, a_done;
  logic [AC-1:0]     a_row_data;
  logic [AI-1:0]     a_row_idx, a_full_count;
  logic [1:0]        a_state;

  logic              b_rst, b_start, b_ready;
  logic [BR*BC-1:0]  b_board;
  logic              b_busy, b_row_valid, b_row_last, b_row_full, b_done;
  logic [BC-1:0]     b_row_data;
  logic [BI-1:0]     b_row_idx, b_full_count;
  logic [1:0]        b_state;

  logic [AC-1:0] a_rows [AR];
  logic [BC-1:0] b_rows [BR];
  logic [14:0]   exp_q [$];
  int checks = 0;
  int errors = 0;

  board_row_streamer #(.ROWS(AR), .COLS(AC), .IDX_W(AI), .SKIP_EMPTY(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .board_flattened(a_board), .start(a_start),
    .busy(a_busy), .row_valid(a_row_valid), .row_ready(a_ready),
    .row_data(a_row_data), .row_idx(a_row_idx), .row_last(a_row_last),
    .row_full(a_row_full), .done(a_done), .full_count(a_full_count),
    .fsm_state(a_state)
  );

  board_row_streamer #(.ROWS(BR), .COLS(BC), .IDX_W(BI), .SKIP_EMPTY(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .board_flattened(b_board), .start(b_start),
    .busy(b_busy), .row_valid(b_row_valid), .row_ready(b_ready),
    .row_data(b_row_data), .row_idx(b_row_idx), .row_last(b_row_last),
    .row_full(b_row_full), .done(b_done), .full_count(b_full_count),
    .fsm_state(b_state)
  );

  task automatic a_build(output logic [AR*AC-1:0] b);
    b = '0;
    for (int r = 0; r < AR; r++) b = (b << AC) | (AR*AC)'(a_rows[r]);
  endtask

  task automatic b_build(output logic [BR*BC-1:0] b);
    b = '0;
    for (int r = 0; r < BR; r++) b = (b << BC) | (BR*BC)'(b_rows[r]);
  endtask

  task automatic test_reset;
    logic [AR*AC-1:0] brd;
    for (int r = 0; r < AR; r++) a_rows[r] = AC'($urandom_range(1, 1023));
    a_build(brd);
    a_board = brd; b_board = 24'hFFFFFF;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b1; b_start = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_row_valid, a_row_data, a_row_idx, a_row_last, a_row_full, a_done,
         a_full_count, a_state} !== '0)
      begin errors++; $display("FAIL reset_a outputs got busy=%b v=%b d=%h i=%0d l=%b f=%b done=%b fc=%0d st=%0d want all 0",
        a_busy, a_row_valid, a_row_data, a_row_idx, a_row_last, a_row_full, a_done, a_full_count, a_state); end
    checks++;
    if ({b_busy, b_row_valid, b_row_data, b_row_idx, b_row_last, b_row_full, b_done,
         b_full_count, b_state} !== '0)
      begin errors++; $display("FAIL reset_b outputs got busy=%b v=%b d=%h i=%0d done=%b fc=%0d want all 0",
        b_busy, b_row_valid, b_row_data, b_row_idx, b_done, b_full_count); end
    a_rst = 1'b0; b_rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0)
      begin errors++; $display("FAIL reset_start_ignored busy got a=%b b=%b want 0 0", a_busy, b_busy); end
  endtask

  // Streams one frame of a_rows through instance A, checking every presented beat.
  task automatic run_a(input int rdy_mode, input bit change_board, input bit check_timing);
    logic [AR*AC-1:0] brd;
    logic [14:0] e, held;
    bit stalled, got_done;
    int cyc, exp_full;
    a_build(brd);
    exp_full = 0;
    for (int r = 0; r < AR; r++) begin
      exp_q.push_back({5'(r), a_rows[r]});
      if (a_rows[r] == 10'h3FF) exp_full++;
    end
    @(negedge clk);
    a_board = brd; a_start = 1'b1; a_ready = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    stalled = 1'b0; got_done = 1'b0; held = '0;
    for (cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (stalled) begin
        checks++;
        if (a_row_valid !== 1'b1 || {a_row_idx, a_row_data} !== held)
          begin errors++; $display("FAIL a_stall_hold got v=%b %h want v=1 %h", a_row_valid, {a_row_idx, a_row_data}, held); end
      end
      a_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (change_board && cyc == 5) a_board = ~brd;
      #1;
      if (a_row_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL a_extra_beat idx=%0d data=%h want no beat", a_row_idx, a_row_data);
        end else begin
          e = exp_q[0];
          if ({a_row_idx, a_row_data} !== e || a_row_last !== (e[14:10] == 5'd22) ||
              a_row_full !== (e[9:0] == 10'h3FF) || a_busy !== 1'b1 ||
              (check_timing && int'(a_row_idx) != cyc))
            begin errors++; $display("FAIL a_beat cyc=%0d got idx=%0d data=%h last=%b full=%b busy=%b want idx=%0d data=%h",
              cyc, a_row_idx, a_row_data, a_row_last, a_row_full, a_busy, e[14:10], e[9:0]); end
          if (a_ready) void'(exp_q.pop_front());
        end
      end
      stalled = a_row_valid && !a_ready;
      held = {a_row_idx, a_row_data};
      if (a_done) begin
        got_done = 1'b1;
        checks++;
        if (exp_q.size() != 0 || int'(a_full_count) != exp_full || a_row_valid !== 1'b0 ||
            a_busy !== 1'b1 || (check_timing && cyc != AR))
          begin errors++; $display("FAIL a_done cyc=%0d left=%0d fc=%0d v=%b busy=%b want left=0 fc=%0d v=0 busy=1",
            cyc, exp_q.size(), a_full_count, a_row_valid, a_busy, exp_full); end
      end
      if (!got_done) @(negedge clk);
    end
    if (!got_done) begin
      checks++; errors++; $display("FAIL a_timeout no done within 400 cycles");
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || int'(a_full_count) != exp_full)
      begin errors++; $display("FAIL a_after_done got done=%b busy=%b fc=%0d want 0 0 %0d", a_done, a_busy, a_full_count, exp_full); end
  endtask

  // Streams one frame of b_rows through the SKIP_EMPTY instance.
  task automatic run_b(input int rdy_mode, input int done_cyc);
    logic [BR*BC-1:0] brd;
    logic [14:0] e;
    bit got_done;
    int cyc, exp_full;
    b_build(brd);
    exp_full = 0;
    for (int r = 0; r < BR; r++) begin
      if (b_rows[r] != '0) exp_q.push_back({5'(r), 4'b0, b_rows[r]});
      if (b_rows[r] == 6'h3F) exp_full++;
    end
    @(negedge clk);
    b_board = brd; b_start = 1'b1; b_ready = 1'b0;
    @(negedge clk);
    b_start = 1'b0;
    got_done = 1'b0;
    for (cyc = 0; cyc < 100 && !got_done; cyc++) begin
      b_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (b_row_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b_extra_beat idx=%0d data=%h want no beat", b_row_idx, b_row_data);
        end else begin
          e = exp_q[0];
          if ({5'(b_row_idx), 4'b0, b_row_data} !== e || b_row_last !== (e[14:10] == 5'd3) ||
              b_row_full !== (e[5:0] == 6'h3F))
            begin errors++; $display("FAIL b_beat got idx=%0d data=%h last=%b full=%b want idx=%0d data=%h",
              b_row_idx, b_row_data, b_row_last, b_row_full, e[14:10], e[5:0]); end
          if (b_ready) void'(exp_q.pop_front());
        end
      end
      if (b_done) begin
        got_done = 1'b1;
        checks++;
        if (exp_q.size() != 0 || int'(b_full_count) != exp_full || b_row_valid !== 1'b0 ||
            (done_cyc >= 0 && cyc != done_cyc))
          begin errors++; $display("FAIL b_done cyc=%0d left=%0d fc=%0d v=%b want cyc=%0d left=0 fc=%0d v=0",
            cyc, exp_q.size(), b_full_count, b_row_valid, done_cyc, exp_full); end
      end
      if (!got_done) @(negedge clk);
    end
    if (!got_done) begin
      checks++; errors++; $display("FAIL b_timeout no done within 100 cycles");
    end
    exp_q.delete();
  endtask

  task automatic test_checkerboard;
    for (int r = 0; r < AR; r++) a_rows[r] = (r % 2 == 0) ? 10'h2AA : 10'h155;
    run_a(0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    for (int r = 0; r < AR; r++) a_rows[r] = (r % 2 == 0) ? 10'h2AA : 10'h155;
    run_a(1, 1'b1, 1'b0);
  endtask

  task automatic test_full_rows;
    for (int r = 0; r < AR; r++) a_rows[r] = AC'($urandom_range(0, 10'h3FE));
    a_rows[5] = 10'h3FE; a_rows[21] = 10'h3FF; a_rows[22] = 10'h3FF;
    run_a(1, 1'b0, 1'b0);
    checks++;
    if (a_full_count !== 5'd2)
      begin errors++; $display("FAIL full_rows_count got %0d want 2", a_full_count); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < AR; r++)
        a_rows[r] = ($urandom_range(0, 3) == 0) ? 10'h3FF : AC'($urandom_range(0, 1023));
      run_a(k, 1'b0, (k == 0));
    end
  endtask

  task automatic test_restart;
    logic [AR*AC-1:0] brd;
    for (int r = 0; r < AR; r++) a_rows[r] = AC'($urandom_range(1, 1023));
    a_build(brd);
    @(negedge clk);
    a_board = brd; a_start = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      checks++;
      if (a_row_valid !== 1'b1 || int'(a_row_idx) != cyc || a_row_data !== a_rows[cyc] || a_done !== 1'b0)
        begin errors++; $display("FAIL restart_beat cyc=%0d got v=%b idx=%0d data=%h done=%b want v=1 idx=%0d data=%h done=0",
          cyc, a_row_valid, a_row_idx, a_row_data, a_done, cyc, a_rows[cyc]); end
      a_start = (cyc == 4);
      if (cyc == 4) a_board = ~brd;
      a_rst = (cyc == 7);
      @(negedge clk);
    end
    a_rst = 1'b0; a_start = 1'b0;
    checks++;
    if ({a_busy, a_row_valid, a_row_data, a_row_idx, a_row_last, a_row_full, a_done, a_full_count} !== '0)
      begin errors++; $display("FAIL restart_rst got busy=%b v=%b idx=%0d done=%b fc=%0d want all 0",
        a_busy, a_row_valid, a_row_idx, a_done, a_full_count); end
    run_a(0, 1'b0, 1'b1);
  endtask

  task automatic test_skip_empty;
    b_rows[0] = 6'h00; b_rows[1] = 6'h3F; b_rows[2] = 6'h00; b_rows[3] = 6'h01;
    run_b(0, 4);
    run_b(1, -1);
    for (int r = 0; r < BR; r++) b_rows[r] = 6'h00;
    run_b(1, 4);
    checks++;
    if (b_full_count !== 3'd0)
      begin errors++; $display("FAIL skip_empty_zero_count got %0d want 0", b_full_count); end
  endtask

  initial begin
    test_reset;
    test_checkerboard;
    test_backpressure;
    test_full_rows;
    test_back_to_back;
    test_restart;
    test_skip_empty;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
